// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/compare/bit-count ops plus multi-cycle
// shift-add multiply and restoring divide sharing one 2*XLEN accumulator.
`timescale 1ns/1ps
module iter_alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_CTZ   = 4'b0110;
    localparam logic [3:0] OP_CLZ   = 4'b0111;
    localparam logic [3:0] OP_CPOP  = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   acc;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            is_div_q;
    logic            hi_q;

    logic [XLEN-1:0] alu_res_c;
    logic            alu_zero_c;
    logic [CW-1:0]   ctz_c;
    logic [CW-1:0]   clz_c;
    logic [CW-1:0]   cpop_c;
    logic            is_iter_c;

    logic [XLEN:0]   mul_sum_c;
    logic [AW-1:0]   mul_next_c;
    logic [XLEN:0]   div_hi_c;
    logic [XLEN:0]   div_diff_c;
    logic [AW-1:0]   div_next_c;
    logic [AW-1:0]   iter_next_c;
    logic [XLEN-1:0] final_res_c;

    // Single-cycle datapath, evaluated on the live request inputs
    always_comb begin
        alu_res_c  = '0;
        alu_zero_c = 1'b0;
        ctz_c      = CW'(XLEN);
        clz_c      = CW'(XLEN);
        cpop_c     = '0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (a[i]) ctz_c = CW'(i);
        end
        for (int i = 0; i < XLEN; i++) begin
            if (a[i]) clz_c = CW'(XLEN - 1 - i);
            cpop_c = cpop_c + CW'(a[i]);
        end
        case (op)
            OP_ADD:  alu_res_c = a + b;
            OP_SUB: begin
                alu_res_c  = a - b;
                alu_zero_c = (a == b);
            end
            OP_AND:  alu_res_c = a & b;
            OP_OR:   alu_res_c = a | b;
            OP_XOR:  alu_res_c = a ^ b;
            OP_SLT: begin
                alu_zero_c = ($signed(a) < $signed(b));
                alu_res_c  = XLEN'(alu_zero_c);
            end
            OP_SLTU: begin
                alu_zero_c = (a < b);
                alu_res_c  = XLEN'(alu_zero_c);
            end
            OP_CTZ:  alu_res_c = XLEN'(ctz_c);
            OP_CLZ:  alu_res_c = XLEN'(clz_c);
            OP_CPOP: alu_res_c = XLEN'(cpop_c);
            OP_DIVU: alu_res_c = '1;
            OP_REMU: alu_res_c = a;
            default: alu_res_c = '0;
        endcase
    end

    assign is_iter_c = (op == OP_MUL) || (op == OP_MULHU) ||
                       (((op == OP_DIVU) || (op == OP_REMU)) && (b != '0));

    // One iteration step: multiplier/dividend enters in the low half
    always_comb begin
        mul_sum_c   = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next_c  = {mul_sum_c, acc[XLEN-1:1]};
        div_hi_c    = acc[AW-1:XLEN-1];
        div_diff_c  = div_hi_c - {1'b0, b_q};
        div_next_c  = div_diff_c[XLEN] ? {div_hi_c[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                       : {div_diff_c[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        iter_next_c = is_div_q ? div_next_c : mul_next_c;
        final_res_c = hi_q ? iter_next_c[AW-1:XLEN] : iter_next_c[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            hi_q      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        // op[2] separates DIVU/REMU from MUL/MULHU, op[0] picks the high half
                        is_div_q <= op[2];
                        hi_q     <= op[0];
                        in_ready <= 1'b0;
                        if (is_iter_c) begin
                            state <= BUSY;
                            cnt   <= CW'(XLEN);
                            acc   <= op[2] ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, b};
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res_c;
                            zero      <= alu_zero_c;
                        end
                    end
                end
                BUSY: begin
                    acc <= iter_next_c;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= final_res_c;
                        zero      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: vector table plus stall, flush and reset sequences.
`timescale 1ns/1ps
module tb_iter_alu;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4,
                           SLT = 4'h5, CTZ = 4'h6, CLZ = 4'h7, CPOP = 4'h8, SLTU = 4'h9,
                           MUL = 4'hA, MULHU = 4'hB, DIVU = 4'hC, REMU = 4'hD;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, zero;
    logic [3:0]  op;
    logic [31:0] a, b, result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    iter_alu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] r, input logic z, input int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.z = z; v.lat = l;
        vecs.push_back(v);
    endtask

    // Handshake on the next rising edge, then scramble inputs to prove they were latched
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        chk("in_ready_before_issue", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'hF; a = 32'hDEAD_BEEF; b = 32'h0;
    endtask

    task automatic wait_result(output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_pop", out_valid, 0);
        chk("in_ready_after_pop", in_ready, 1);
    endtask

    initial begin
        int lat;
        bit rdy_seen;
        bit seen;

        add_vec(ADD,   32'd5,        32'd7,        32'd12,       1'b0, 1);
        add_vec(SUB,   32'd9,        32'd9,        32'd0,        1'b1, 1);
        add_vec(SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1);
        add_vec(SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        add_vec(CTZ,   32'h00000100, 32'd0,        32'd8,        1'b0, 1);
        add_vec(CLZ,   32'h0,        32'd0,        32'd32,       1'b0, 1);
        add_vec(CPOP,  32'hF0F00001, 32'd0,        32'd9,        1'b0, 1);
        add_vec(MUL,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b0, 33);
        add_vec(MULHU, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 33);
        add_vec(DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 33);
        add_vec(REMU,  32'd100,      32'd7,        32'd2,        1'b0, 33);
        add_vec(DIVU,  32'd13,       32'd0,        32'hFFFFFFFF, 1'b0, 1);
        add_vec(REMU,  32'd13,       32'd0,        32'd13,       1'b0, 1);
        add_vec(ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        add_vec(SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        add_vec(AND_,  32'hF0,       32'h3C,       32'h30,       1'b0, 1);
        add_vec(OR_,   32'hF0,       32'h3C,       32'hFC,       1'b0, 1);
        add_vec(XOR_,  32'hF0,       32'h3C,       32'hCC,       1'b0, 1);
        add_vec(SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1);
        add_vec(SLTU,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b1, 1);
        add_vec(CTZ,   32'h0,        32'd0,        32'd32,       1'b0, 1);
        add_vec(CTZ,   32'h80000000, 32'd0,        32'd31,       1'b0, 1);
        add_vec(CLZ,   32'h1,        32'd0,        32'd31,       1'b0, 1);
        add_vec(CLZ,   32'h80000000, 32'd0,        32'd0,        1'b0, 1);
        add_vec(CPOP,  32'hFFFFFFFF, 32'd0,        32'd32,       1'b0, 1);
        add_vec(MUL,   32'd12345,    32'd1000,     32'd12345000, 1'b0, 33);
        add_vec(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        add_vec(DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33);
        add_vec(REMU,  32'd7,        32'd100,      32'd7,        1'b0, 33);
        add_vec(4'hE,  32'd5,        32'd5,        32'd0,        1'b0, 1);
        add_vec(4'hF,  32'd5,        32'd0,        32'd0,        1'b0, 1);

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = 4'h0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_zero", zero, 0);

        // Request already waiting when reset releases: accepted on the first edge
        op = ADD; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_edge_out_valid", out_valid, 1);
        chk("first_edge_result", result, 32'd5);
        pop();

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(lat, rdy_seen);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("v%0d_in_ready_low", i), rdy_seen, 0);
            pop();
        end

        // Backpressure: result held, competing request ignored
        issue(ADD, 32'd5, 32'd7);
        wait_result(lat, rdy_seen);
        op = SUB; a = 32'd9; b = 32'd9; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_out_valid", c), out_valid, 1);
            chk($sformatf("stall%0d_result", c), result, 32'd12);
            chk($sformatf("stall%0d_zero", c), zero, 0);
            chk($sformatf("stall%0d_in_ready", c), in_ready, 0);
        end
        in_valid = 1'b0;
        pop();
        @(posedge clk); #1;
        chk("stall_result_after_pop", result, 32'd12);

        // Flush during the 10th cycle of a multiply
        issue(MUL, 32'hFFFFFFFF, 32'd2);
        repeat (9) @(posedge clk);
        #1;
        chk("mul_busy_in_ready", in_ready, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_result_kept", result, 32'd12);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_out_valid", seen, 0);

        // Flush wins over the output handshake in DONE
        issue(ADD, 32'd1, 32'd2);
        wait_result(lat, rdy_seen);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        chk("flush_done_out_valid", out_valid, 0);
        chk("flush_done_in_ready", in_ready, 1);
        chk("flush_done_result", result, 32'd3);

        // Asynchronous reset in the 20th cycle of a divide
        issue(DIVU, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_out_valid", seen, 0);
        issue(ADD, 32'd1, 32'd1);
        wait_result(lat, rdy_seen);
        chk("post_rst_latency", lat, 1);
        chk("post_rst_result", result, 32'd2);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
